// File: rtl/utype_seq_ctrl_if.sv
// Instruction-fetch and register-file writeback bus of the U-type sequencer.
// The master is the sequencer; the slave is the memory/register-file side.
interface utype_seq_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  modport master (
    output imem_req, imem_addr, rf_we, rf_waddr, rf_wdata,
    input  imem_ack, imem_rdata
  );
  modport slave (
    input  imem_req, imem_addr, rf_we, rf_waddr, rf_wdata,
    output imem_ack, imem_rdata
  );
endinterface

// File: rtl/utype_seq_ctrl.sv
// Multi-cycle sequencer executing LUI/AUIPC: FETCH -> DECODE -> EXEC -> WB.
// Any other opcode raises a sticky illegal flag and returns to IDLE.
module utype_seq_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               halt,
  utype_seq_ctrl_if.master   bus,
  output logic [31:0]        pc,
  output logic               busy,
  output logic               illegal
);
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WB} state_t;

  state_t      state, state_nx;
  logic [31:0] inst;
  logic [19:0] imm;
  logic [4:0]  rd;
  logic [6:0]  opc;
  logic [31:0] result;
  logic        legal;

  assign legal = (opc == OP_LUI) || (opc == OP_AUIPC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start)        state_nx = FETCH;
      FETCH:   if (bus.imem_ack) state_nx = DECODE;
      DECODE:  state_nx = EXEC;
      EXEC:    state_nx = legal ? WB : IDLE;
      WB:      state_nx = halt ? IDLE : FETCH;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc      <= RESET_PC;
      inst    <= '0;
      imm     <= '0;
      rd      <= '0;
      opc     <= '0;
      result  <= '0;
      illegal <= 1'b0;
    end else begin
      case (state)
        IDLE:   if (start) illegal <= 1'b0;
        FETCH:  if (bus.imem_ack) inst <= bus.imem_rdata;
        DECODE: begin
          imm <= inst[31:12];
          rd  <= inst[11:7];
          opc <= inst[6:0];
        end
        EXEC: begin
          case (opc)
            OP_LUI:   result <= {imm, 12'h000};
            OP_AUIPC: result <= pc + {imm, 12'h000};
            default:  illegal <= 1'b1;
          endcase
        end
        WB:      pc <= pc + 32'd4;
        default: ;
      endcase
    end
  end

  // Outputs decode straight from state so reset drops req/we without waiting for a clock.
  assign busy          = (state != IDLE);
  assign bus.imem_req  = (state == FETCH);
  assign bus.imem_addr = pc;
  assign bus.rf_we     = (state == WB) && (rd != 5'd0);
  assign bus.rf_waddr  = rd;
  assign bus.rf_wdata  = result;
endmodule

// File: tb/tb_utype_seq_ctrl.sv
// Directed bench for utype_seq_ctrl: LUI, AUIPC, rd=0, illegal, reset, wrap/stall/halt.
module tb_utype_seq_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start0 = 1'b0, halt0 = 1'b0;
  logic start1 = 1'b0, halt1 = 1'b0;
  logic [31:0] pc0, pc1;
  logic busy0, busy1, ill0, ill1;
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  utype_seq_ctrl_if b0 ();
  utype_seq_ctrl_if b1 ();

  utype_seq_ctrl u0 (
    .clk(clk), .rst(rst), .start(start0), .halt(halt0), .bus(b0.master),
    .pc(pc0), .busy(busy0), .illegal(ill0)
  );

  utype_seq_ctrl #(.RESET_PC(32'hFFFF_FFFC)) u1 (
    .clk(clk), .rst(rst), .start(start1), .halt(halt1), .bus(b1.master),
    .pc(pc1), .busy(busy1), .illegal(ill1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called one step after FETCH entry with ack in the first FETCH cycle; returns
  // one step after the following state entry (FETCH, or IDLE when halted).
  // ack is held through DECODE with garbage data to show it is ignored there.
  task automatic exec_u(input logic [31:0] word, input logic [31:0] pc_exp,
                        input logic we_exp, input logic [4:0] rd_exp,
                        input logic [31:0] data_exp);
    chk("fetch_req", {31'd0, b0.imem_req}, 32'd1);
    chk("fetch_addr", b0.imem_addr, pc_exp);
    b0.imem_ack = 1'b1; b0.imem_rdata = word;
    tick();
    b0.imem_rdata = 32'hFFFF_FFFF;
    chk("dec_we", {31'd0, b0.rf_we}, 32'd0);
    chk("dec_req", {31'd0, b0.imem_req}, 32'd0);
    tick();
    b0.imem_ack = 1'b0; b0.imem_rdata = 32'h0;
    chk("exe_we", {31'd0, b0.rf_we}, 32'd0);
    tick();
    chk("wb_we", {31'd0, b0.rf_we}, {31'd0, we_exp});
    if (we_exp) begin
      chk("wb_waddr", {27'd0, b0.rf_waddr}, {27'd0, rd_exp});
      chk("wb_wdata", b0.rf_wdata, data_exp);
    end
    chk("wb_pc", pc0, pc_exp);
    tick();
  endtask

  initial begin
    b0.imem_ack = 1'b0; b0.imem_rdata = 32'h0;
    b1.imem_ack = 1'b0; b1.imem_rdata = 32'h0;
    #12;
    chk("rst_busy", {31'd0, busy0}, 32'd0);
    chk("rst_pc", pc0, 32'h0);
    chk("rst_req", {31'd0, b0.imem_req}, 32'd0);
    chk("rst_we", {31'd0, b0.rf_we}, 32'd0);
    chk("rst_ill", {31'd0, ill0}, 32'd0);
    chk("rst_waddr", {27'd0, b0.rf_waddr}, 32'd0);
    chk("rst_wdata", b0.rf_wdata, 32'h0);
    chk("rst_pc1", pc1, 32'hFFFF_FFFC);
    @(negedge clk); rst = 1'b0;
    tick();
    chk("idle_busy", {31'd0, busy0}, 32'd0);

    // LUI x5
    start0 = 1'b1; tick(); start0 = 1'b0;
    chk("start_busy", {31'd0, busy0}, 32'd1);
    exec_u(32'h1234_52B7, 32'h0, 1'b1, 5'd5, 32'h1234_5000);
    // 63 x "lui x0,0": never writes, walks pc to 0x100 at 4 cycles each
    for (int i = 1; i < 64; i++)
      exec_u(32'h0000_0037, 32'(4 * i), 1'b0, 5'd0, 32'h0);
    exec_u(32'h0000_1097, 32'h100, 1'b1, 5'd1, 32'h0000_1100);
    exec_u(32'h1234_5037, 32'h104, 1'b0, 5'd0, 32'h0);

    // illegal opcode
    chk("ill_addr", b0.imem_addr, 32'h108);
    b0.imem_ack = 1'b1; b0.imem_rdata = 32'h0000_0013;
    tick();
    b0.imem_ack = 1'b0; b0.imem_rdata = 32'h0;
    tick();
    chk("ill_exe_we", {31'd0, b0.rf_we}, 32'd0);
    tick();
    chk("ill_flag", {31'd0, ill0}, 32'd1);
    chk("ill_busy", {31'd0, busy0}, 32'd0);
    chk("ill_pc", pc0, 32'h108);
    chk("ill_we", {31'd0, b0.rf_we}, 32'd0);
    tick();
    chk("ill_sticky", {31'd0, ill0}, 32'd1);
    start0 = 1'b1; tick(); start0 = 1'b0;
    chk("ill_clear", {31'd0, ill0}, 32'd0);
    chk("restart_req", {31'd0, b0.imem_req}, 32'd1);
    chk("restart_addr", b0.imem_addr, 32'h108);

    // asynchronous reset in the middle of FETCH
    #3 rst = 1'b1;
    #1;
    chk("arst_req", {31'd0, b0.imem_req}, 32'd0);
    chk("arst_pc", pc0, 32'h0);
    chk("arst_busy", {31'd0, busy0}, 32'd0);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("post_rst_we", {31'd0, b0.rf_we}, 32'd0);
      chk("post_rst_busy", {31'd0, busy0}, 32'd0);
    end

    // wrap + fetch stall + halt raised during FETCH on the second instance
    start1 = 1'b1; halt1 = 1'b1; tick(); start1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stall_req", {31'd0, b1.imem_req}, 32'd1);
      chk("stall_addr", b1.imem_addr, 32'hFFFF_FFFC);
      tick();
    end
    chk("stall_req4", {31'd0, b1.imem_req}, 32'd1);
    b1.imem_ack = 1'b1; b1.imem_rdata = 32'h0000_1137;
    tick();
    b1.imem_ack = 1'b0; b1.imem_rdata = 32'h0;
    chk("halt_dec_busy", {31'd0, busy1}, 32'd1);
    tick();
    tick();
    chk("wrap_we", {31'd0, b1.rf_we}, 32'd1);
    chk("wrap_waddr", {27'd0, b1.rf_waddr}, 32'd2);
    chk("wrap_wdata", b1.rf_wdata, 32'h0000_1000);
    tick();
    chk("wrap_pc", pc1, 32'h0);
    chk("halt_busy", {31'd0, busy1}, 32'd0);
    chk("halt_req", {31'd0, b1.imem_req}, 32'd0);
    chk("halt_we", {31'd0, b1.rf_we}, 32'd0);
    halt1 = 1'b0;
    tick();
    chk("halt_stay", {31'd0, busy1}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/utype_seq_ctrl.md
UTYPE_SEQ_CTRL -- requirements
Module: utype_seq_ctrl

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  level; begins sequencing from IDLE.
REQ-005 SHALL have port: halt  input  1  level; stop after current instruction retires.
REQ-006 SHALL have port: imem_req  output  1  instruction fetch request.
REQ-007 SHALL have port: imem_addr  output  32  fetch address, equal to pc.
REQ-008 SHALL have port: imem_ack  input  1  fetch complete; imem_rdata valid this cycle.
REQ-009 SHALL have port: imem_rdata  input  32  fetched instruction word.
REQ-010 SHALL have port: rf_we  output  1  one-cycle register-file write strobe.
REQ-011 SHALL have port: rf_waddr  output  5  destination register (inst[11:7]).
REQ-012 SHALL have port: rf_wdata  output  32  writeback value.
REQ-013 SHALL have port: pc  output  32  current program counter.
REQ-014 SHALL have port: busy  output  1  high in every state except IDLE.
REQ-015 SHALL have port: illegal  output  1  sticky flag; non-U-type opcode seen.

Function
REQ-016 SHALL implement FSM states IDLE, FETCH, DECODE, EXEC, WB; encoding free.
REQ-017 IDLE: on start=1 SHALL clear illegal and go to FETCH next cycle; else stay.
REQ-018 FETCH: imem_req=1, imem_addr=pc held stable until imem_ack; on imem_ack SHALL capture imem_rdata into instruction register and go to DECODE.
REQ-019 imem_ack while not in FETCH SHALL be ignored.
REQ-020 DECODE: SHALL split captured word into imm=inst[31:12], rd=inst[11:7], opcode=inst[6:0]; go to EXEC.
REQ-021 EXEC: opcode 7'b0110111 (LUI) result={imm,12'h000}; opcode 7'b0010111 (AUIPC) result=pc+{imm,12'h000}, 32-bit modulo; go to WB.
REQ-022 EXEC with any other opcode SHALL set illegal=1, perform no write, leave pc unchanged, go to IDLE.
REQ-023 WB: rf_we=1 for exactly one cycle with rf_waddr=rd, rf_wdata=result, suppressed (rf_we=0) when rd=0.
REQ-024 WB: pc SHALL advance by 4, modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-025 WB exit: halt=1 sampled in WB -> IDLE; else -> FETCH.
REQ-026 halt asserted in FETCH/DECODE/EXEC SHALL NOT abort; current instruction completes, halt checked only in WB.
REQ-027 start while busy SHALL be ignored.
REQ-028 Latency per legal instruction SHALL be 4 cycles plus fetch wait cycles (ack in first FETCH cycle -> 4 cycles FETCH-entry to next FETCH-entry).
REQ-029 rf_waddr/rf_wdata outside WB are don't-care; rf_we SHALL be 0 outside WB.

Reset
REQ-030 rst=1 SHALL immediately force IDLE, pc=RESET_PC, imem_req=0, rf_we=0, busy=0, illegal=0, instruction register=0, rf_waddr=0, rf_wdata=0.
REQ-031 Reset mid-fetch or mid-WB SHALL drop any pending request/write that cycle; no write after reset deasserts until a new start.

Verification
REQ-032 LUI: pc=0, start, imem_rdata=32'h1234_52B7 ack in 1st FETCH cycle -> WB: rf_we=1, rf_waddr=5, rf_wdata=32'h1234_5000; pc=4; 4-cycle loop.
REQ-033 AUIPC: pc=32'h100, imem_rdata=32'h0000_1097 -> rf_waddr=1, rf_wdata=32'h0000_1100, pc=32'h104.
REQ-034 rd=0: imem_rdata=32'h1234_5037 -> rf_we stays 0 entire instruction, pc advances by 4.
REQ-035 Illegal: imem_rdata=32'h0000_0013 -> illegal=1, no rf_we, pc unchanged, busy=0; next start clears illegal.
REQ-036 Wrap/stall/halt: RESET_PC=32'hFFFF_FFFC, ack delayed 3 cycles with imem_addr stable, halt=1 during FETCH -> single retire, pc=0, IDLE.
REQ-037 Reset mid-operation: rst pulsed during FETCH with imem_req=1 -> imem_req=0 asynchronously, pc=RESET_PC, IDLE, no rf_we.
